// File: rtl/floo_pkg.sv
// Shared response-metadata types for the FlooNoC chimney trackers.
package floo_pkg;

    localparam int unsigned MetaRobIdxWidth = 6;
    localparam int unsigned MetaDestWidth   = 8;

    typedef struct packed {
        logic                       rob_req;
        logic [MetaRobIdxWidth-1:0] rob_idx;
        logic [MetaDestWidth-1:0]   src_id;
    } rsp_meta_t;

    function automatic rsp_meta_t pack_rsp_meta(
        input logic                       rob_req,
        input logic [MetaRobIdxWidth-1:0] rob_idx,
        input logic [MetaDestWidth-1:0]   src_id
    );
        rsp_meta_t m;
        m.rob_req = rob_req;
        m.rob_idx = rob_idx;
        m.src_id  = src_id;
        return m;
    endfunction

endpackage

// File: rtl/floo_meta_fifo.sv
// One per-AXI-ID circular buffer of request metadata; head is the oldest entry.
module floo_meta_fifo
    import floo_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth) + 1;

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr, rd_ptr;
    logic [CntWidth-1:0] count;

    function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count == CntWidth'(Depth));
    assign empty_o = (count == '0);
    assign head_o  = mem[rd_ptr];

    // Storage is left unreset; emptiness alone decides whether head is meaningful.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop_i) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push_i && !pop_i) begin
                count <= count + 1'b1;
            end else if (pop_i && !push_i) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/floo_rsp_meta_tracker.sv
// Responder-side metadata tracker: stores per-ID request metadata, re-attaches it to responses.
// Optional macro FLOO_RSP_META_ORPHAN_DROP_EN drops orphan responses and raises sticky err_o.
module floo_rsp_meta_tracker
    import floo_pkg::*;
#(
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned MaxTxnsPerId = 4,
    parameter int unsigned RobIdxWidth  = 6,
    parameter int unsigned DestWidth    = 8,
    parameter int unsigned MetaWidth    = 1 + RobIdxWidth + DestWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [IdWidth-1:0]   req_id_i,
    input  logic [MetaWidth-1:0] req_meta_i,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic [IdWidth-1:0]   rsp_id_i,
    input  logic                 rsp_last_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [MetaWidth-1:0] rsp_meta_o,
    output logic                 idle_o,
    output logic                 err_o
);

    localparam int unsigned NumIds = 2 ** IdWidth;

    logic [NumIds-1:0]    push, pop, full, empty;
    logic [MetaWidth-1:0] head [NumIds];
    logic                 req_full, rsp_empty;
    logic                 push_any, pop_any;

    assign req_full  = full[req_id_i];
    assign rsp_empty = empty[rsp_id_i];

    assign req_valid_o = !rst_i && req_valid_i && !req_full;
    assign req_ready_o = !rst_i && req_ready_i && !req_full;
    assign push_any    = req_valid_i && req_ready_o;
    assign pop_any     = rsp_valid_i && rsp_ready_o && rsp_last_i && !rsp_empty;

    assign rsp_meta_o = rsp_empty ? '0 : head[rsp_id_i];
    assign idle_o     = &empty;

`ifdef FLOO_RSP_META_ORPHAN_DROP_EN
    logic orphan;
    assign orphan      = rsp_valid_i && rsp_empty;
    assign rsp_valid_o = !rst_i && rsp_valid_i && !orphan;
    assign rsp_ready_o = !rst_i && (orphan || rsp_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (orphan) begin
            err_o <= 1'b1;
        end
    end
`else
    assign rsp_valid_o = !rst_i && rsp_valid_i;
    assign rsp_ready_o = !rst_i && rsp_ready_i;
    assign err_o       = 1'b0;
`endif

    always_comb begin
        push = '0;
        pop  = '0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            push[i] = push_any && (req_id_i == IdWidth'(i));
            pop[i]  = pop_any && (rsp_id_i == IdWidth'(i));
        end
    end

    for (genvar g = 0; g < NumIds; g++) begin : gen_fifo
        floo_meta_fifo #(
            .Depth (MaxTxnsPerId),
            .Width (MetaWidth)
        ) i_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push[g]),
            .data_i  (req_meta_i),
            .pop_i   (pop[g]),
            .head_o  (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g])
        );
    end

endmodule

// File: doc/floo_rsp_meta_tracker.md
Name: floo_rsp_meta_tracker

Overview:
- Subordinate-side (responder) counterpart of the initiator-side reorder/ordering logic.
- Captures the NoC metadata of each incoming request before it is handed to the local AXI port: rob_req, rob_idx and source node ID.
- Re-attaches that metadata to the matching response so the chimney can route it back and the initiator RoB can place it.
- Keeps a per-AXI-ID in-order FIFO of metadata. AXI guarantees same-ID response ordering, so the FIFO head always matches the response.

Parameters:
- IdWidth, 4, width of the AXI ID; the table holds 2**IdWidth per-ID FIFOs.
- MaxTxnsPerId, 4, depth of each per-ID FIFO; must be >=1 and a power of two.
- RobIdxWidth, 6, width of the RoB index.
- DestWidth, 8, width of the source/destination node ID.
- MetaWidth, 1+RobIdxWidth+DestWidth, derived; packed as {rob_req, rob_idx, src_id}.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request (AW or AR) from NoC valid
- req_ready_o  out  1  request accepted
- req_id_i  in  IdWidth  AXI ID of request
- req_meta_i  in  MetaWidth  metadata to store
- req_valid_o  out  1  request to local AXI valid
- req_ready_i  in  1  local AXI ready
- rsp_valid_i  in  1  response (B or R) from local AXI valid
- rsp_ready_o  out  1  response accepted
- rsp_id_i  in  IdWidth  AXI ID of response
- rsp_last_i  in  1  last beat (tie to 1 for B)
- rsp_valid_o  out  1  response to NoC valid
- rsp_ready_i  in  1  NoC ready
- rsp_meta_o  out  MetaWidth  metadata for the response
- idle_o  out  1  no transaction outstanding on any ID
- err_o  out  1  sticky orphan-response flag (see Optional Feature)

Behaviour:
- State per ID:
  - metadata array [MaxTxnsPerId]
  - wr_ptr, rd_ptr, each $clog2(MaxTxnsPerId) bits, wrap modulo depth
  - count, $clog2(MaxTxnsPerId)+1 bits
- full[id] = (count == MaxTxnsPerId); empty[id] = (count == 0).
- Request path, combinational, zero latency:
  - req_valid_o = req_valid_i && !full[req_id_i]
  - req_ready_o = req_ready_i && !full[req_id_i]
  - push = req_valid_i && req_ready_o: write req_meta_i at wr_ptr, advance wr_ptr, count+1.
- Full ID: request stalls and nothing is pushed. Other IDs are unaffected at the block level; any head-of-line blocking is upstream.
- Response path, combinational:
  - rsp_meta_o = head entry of FIFO[rsp_id_i]
  - rsp_ready_o = rsp_ready_i
  - rsp_valid_o = rsp_valid_i
  - pop = rsp_valid_i && rsp_ready_i && rsp_last_i && !empty[rsp_id_i]: advance rd_ptr, count-1.
  - Non-last beats do not pop; the same meta is repeated for every R beat.
- Simultaneous push and pop, same ID: both apply and count is unchanged. A full FIFO still blocks the push; there is no pop-to-push bypass.
- Push into an empty ID while a response for that ID arrives in the same cycle: no write-to-read bypass, so the response sees the ID as empty (orphan).
- idle_o = all counts zero, registered-free (combinational from state).
- Reset: while rst_i=1, req_valid_o, req_ready_o, rsp_valid_o and rsp_ready_o are forced to 0.
  - All pointers and counts are cleared at the clock edge.
  - err_o is cleared.
  - rsp_meta_o = '0 and idle_o = 1 after reset.
- Reset mid-operation discards all tracked metadata. Later responses for dropped transactions are orphans.
- Orphan response (empty FIFO for rsp_id_i) with the feature off: forwarded with rsp_meta_o='0, no state change.

Optional Feature:
- Macro: FLOO_RSP_META_ORPHAN_DROP_EN.
- Defined:
  - For an orphan response, rsp_valid_o=0 and rsp_ready_o=1, so the beat is consumed and dropped.
  - err_o is set on the first orphan beat and stays set until reset.
- Undefined:
  - Orphans are forwarded with meta '0 as described above.
  - err_o is tied to 0.

Decomposition:
- floo_pkg gets the following:
  - typedef rsp_meta_t, a packed struct {rob_req, rob_idx, src_id}
  - function pack_rsp_meta
- Sub-module floo_meta_fifo: one per-ID circular buffer with push, pop, head, full and empty. Instantiated 2**IdWidth times in a generate loop.
- Top level handles ID decoding, the handshake gating and err_o.

Test Plan:
- Three writes on ID 2 with meta 0x101, 0x102, 0x103, then three B responses with ID 2 -> rsp_meta_o is 0x101, 0x102, 0x103 in order; idle_o returns to 1.
- Four requests on ID 5 (depth 4), then a fifth -> fifth sees req_ready_o=0 and req_valid_o=0. One B pop on ID 5 in the same cycle does not admit it; it is accepted the next cycle.
- Read with 4 beats on ID 1 (meta 0x0A7) interleaved with a B on ID 3 (meta 0x055) -> all 4 R beats carry 0x0A7; only the last beat pops; ID 3 returns 0x055.
- rsp_ready_i=0 for 3 cycles with a last beat pending -> no pop and meta held stable; pop occurs on the handshake cycle.
- Response on empty ID 7:
  - Feature off: forwarded with meta 0 and err_o=0.
  - Feature on: consumed with rsp_valid_o=0 and err_o=1 until reset.
- Two entries outstanding on ID 0, then rst_i=1 for 1 cycle -> readies and valids are 0 during reset; idle_o=1 and err_o=0 afterwards; the next response on ID 0 is treated as an orphan.
